mem_protocol_checker: RTL and testbench
=======================================

Name: mem_protocol_checker

Overview:
Synthesizable, parametrised protocol checker for the single-port valid/ready memory interface. It connects in parallel with the memory, observes every DUT signal, and drives no DUT input. It replaces the fixed single-cycle handshake and reset assertions with a configurable-latency handshake FSM, stability checks, sticky error flags, counters and an optional shadow-memory data scoreboard. It is usable in simulation and on FPGA.

Parameters:
ADDR_WIDTH, 4, address width of monitored memory
WIDTH, 16, data width
MAX_WAIT, 1, max cycles after valid_i assertion for ready_o (>=1)
CNT_WIDTH, 16, width of error and transaction counters

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous active-high reset
valid_i  input  1  observed request valid
wr_rd_i  input  1  observed direction, 1=write 0=read
addr_i  input  ADDR_WIDTH  observed address
wdata_i  input  WIDTH  observed write data
rdata_o  input  WIDTH  observed read data (DUT output)
ready_o  input  1  observed ready (DUT output)
clr_i  input  1  clear sticky flags and counters
chk_err_o  output  1  one-cycle pulse, any new error this cycle
chk_err_vec_o  output  6  sticky: [0]RST [1]TIMEOUT [2]DROP [3]STABLE [4]SPURIOUS [5]DATA
chk_err_cnt_o  output  CNT_WIDTH  errors detected, saturating
chk_txn_cnt_o  output  CNT_WIDTH  completed transactions, wrapping

Behaviour:
- All outputs are registered. While rst_i=1, every output is 0, the FSM is RST_CHK, and the wait counter is 0. clr_i zeroes the vector and counters but not the FSM. rst_i has priority over clr_i.
- rst_q is a one-cycle-delayed copy of rst_i. In any cycle with rst_q=1, rdata_o!=0 or ready_o=1 raises RST.
- States:
  - RST_CHK: entered on reset. Moves to IDLE on the first cycle with rst_i=0.
  - IDLE:
    - valid_i&ready_o completes the transaction in the same cycle.
    - valid_i&!ready_o captures addr/wdata/wr_rd, sets wait_cnt=1, and moves to WAIT.
    - !valid_i&ready_o raises SPURIOUS.
  - WAIT:
    - ready_o&valid_i completes the transaction and moves to IDLE.
    - !valid_i raises DROP and moves to IDLE.
    - Any change of addr_i/wdata_i/wr_rd_i from the captured values while valid_i=1 raises STABLE. The FSM stays in WAIT.
    - !ready_o with wait_cnt==MAX_WAIT raises TIMEOUT and moves to IDLE. The request is discarded.
    - Otherwise wait_cnt increments.
- Transaction complete: chk_txn_cnt_o+1 (wraps at 2^CNT_WIDTH). A request with valid_i still high in the cycle after completion counts as a new request.
- Error accounting:
  - Errors are visible one cycle after the offending sample.
  - Several error bits in the same cycle are all set, chk_err_o pulses once, and chk_err_cnt_o increments by 1.
  - chk_err_cnt_o saturates at all-ones.
  - clr_i in the same cycle as a new error: the clear wins for the counters and vector, but the chk_err_o pulse is still issued.
- Reset mid-transaction: the capture is discarded and no TIMEOUT or DROP is raised.
- STABLE is reported at most once per WAIT episode.

Optional Feature:
SCOREBOARD_EN
- Defined:
  - Adds a shadow memory of 2^ADDR_WIDTH x WIDTH and per-entry written bits. All written bits clear on rst_i.
  - A completed write stores wdata_i.
  - A completed read compares rdata_o in the completion cycle against the shadow entry, only if that entry has been written. A mismatch raises DATA.
  - Reads of unwritten addresses are not checked.
- Undefined: chk_err_vec_o[5] is tied 0 and no shadow storage is generated.

Test Plan:
- Reset: rst_i=1 for 3 cycles with DUT rdata_o=0, ready_o=0 -> all outputs 0, no RST. Force ready_o=1 in the cycle after reset -> chk_err_vec_o=6'b000001, chk_err_cnt_o=1.
- Handshake: MAX_WAIT=2; write addr=3 data=16'hA5A5, ready_o after 2 cycles -> chk_txn_cnt_o=1, no error. Ready after 3 cycles -> TIMEOUT set, chk_err_cnt_o=1.
- Protocol violations: in WAIT, change addr 3->4 -> STABLE. Drop valid_i before ready -> DROP. ready_o=1 with valid_i=0 in IDLE -> SPURIOUS. chk_err_cnt_o=3, vector=6'b011100.
- Simultaneous events: STABLE and TIMEOUT in the same cycle -> both bits set, chk_err_cnt_o+1 only. Assert clr_i -> vector and counters 0 next cycle.
- Scoreboard (SCOREBOARD_EN): write 16'h1234 to addr 5, then read addr 5 returning 16'h1235 -> DATA set. Read of unwritten addr 7 returning anything -> no error.
- Saturation: CNT_WIDTH=4 with 20 SPURIOUS errors -> chk_err_cnt_o holds 4'hF.

Source files
------------

// File: rtl/mem_protocol_checker.sv
// Passive protocol checker for a single-port valid/ready memory interface.
// Define SCOREBOARD_EN to add a shadow-memory read-data check (error bit 5, DATA).
module mem_protocol_checker #(
  parameter int ADDR_WIDTH = 4,
  parameter int WIDTH      = 16,
  parameter int MAX_WAIT   = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  input  logic                  wr_rd_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic [WIDTH-1:0]      rdata_o,
  input  logic                  ready_o,
  input  logic                  clr_i,
  output logic                  chk_err_o,
  output logic [5:0]            chk_err_vec_o,
  output logic [CNT_WIDTH-1:0]  chk_err_cnt_o,
  output logic [CNT_WIDTH-1:0]  chk_txn_cnt_o
);

  localparam int WCW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] MAX_WAIT_C = WCW'(MAX_WAIT);

  localparam int E_RST     = 0;
  localparam int E_TIMEOUT = 1;
  localparam int E_DROP    = 2;
  localparam int E_STABLE  = 3;
  localparam int E_SPUR    = 4;

  typedef enum logic [1:0] {
    RST_CHK = 2'd0,
    IDLE    = 2'd1,
    WAIT    = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [WCW-1:0]         wait_cnt_q, wait_cnt_d;
  logic [ADDR_WIDTH-1:0]  cap_addr_q, cap_addr_d;
  logic [WIDTH-1:0]       cap_wdata_q, cap_wdata_d;
  logic                   cap_wr_q, cap_wr_d;
  logic                   stable_rep_q, stable_rep_d;
  logic                   rst_q;
  logic                   err_pulse_q;
  logic [5:0]             err_vec_q;
  logic [CNT_WIDTH-1:0]   err_cnt_q;
  logic [CNT_WIDTH-1:0]   txn_cnt_q;

  logic [4:0]             proto_err;
  logic                   data_err;
  logic [5:0]             err_now;
  logic                   txn_done;
  logic                   req_changed;

  assign req_changed = (addr_i != cap_addr_q) || (wdata_i != cap_wdata_q) ||
                       (wr_rd_i != cap_wr_q);

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    cap_addr_d   = cap_addr_q;
    cap_wdata_d  = cap_wdata_q;
    cap_wr_d     = cap_wr_q;
    stable_rep_d = stable_rep_q;
    proto_err    = '0;
    txn_done     = 1'b0;

    if (rst_q && ((rdata_o != '0) || ready_o)) proto_err[E_RST] = 1'b1;

    case (state_q)
      RST_CHK: state_d = IDLE;
      IDLE: begin
        if (valid_i && ready_o) begin
          txn_done = 1'b1;
        end else if (valid_i) begin
          cap_addr_d   = addr_i;
          cap_wdata_d  = wdata_i;
          cap_wr_d     = wr_rd_i;
          wait_cnt_d   = WCW'(1);
          stable_rep_d = 1'b0;
          state_d      = WAIT;
        end else if (ready_o) begin
          proto_err[E_SPUR] = 1'b1;
        end
      end
      WAIT: begin
        // A changed request is flagged once per episode; the timeout still runs.
        if (valid_i && !stable_rep_q && req_changed) begin
          proto_err[E_STABLE] = 1'b1;
          stable_rep_d        = 1'b1;
        end
        if (!valid_i) begin
          proto_err[E_DROP] = 1'b1;
          wait_cnt_d        = '0;
          state_d           = IDLE;
        end else if (ready_o) begin
          txn_done   = 1'b1;
          wait_cnt_d = '0;
          state_d    = IDLE;
        end else if (wait_cnt_q == MAX_WAIT_C) begin
          proto_err[E_TIMEOUT] = 1'b1;
          wait_cnt_d           = '0;
          state_d              = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + WCW'(1);
        end
      end
      default: state_d = RST_CHK;
    endcase
  end

`ifdef SCOREBOARD_EN
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [WIDTH-1:0] shadow_q [DEPTH];
  logic [DEPTH-1:0] written_q;

  // Shadow data needs no reset; only the written bits gate the comparison.
  always_ff @(posedge clk_i) begin
    if (!rst_i && txn_done && wr_rd_i) shadow_q[addr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      written_q <= '0;
    end else if (txn_done && wr_rd_i) begin
      written_q[addr_i] <= 1'b1;
    end
  end

  assign data_err = txn_done && !wr_rd_i && written_q[addr_i] &&
                    (rdata_o != shadow_q[addr_i]);
`else
  assign data_err = 1'b0;
`endif

  assign err_now = {data_err, proto_err};

  always_ff @(posedge clk_i) begin
    rst_q <= rst_i;
    if (rst_i) begin
      state_q      <= RST_CHK;
      wait_cnt_q   <= '0;
      cap_addr_q   <= '0;
      cap_wdata_q  <= '0;
      cap_wr_q     <= 1'b0;
      stable_rep_q <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_vec_q    <= '0;
      err_cnt_q    <= '0;
      txn_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      cap_addr_q   <= cap_addr_d;
      cap_wdata_q  <= cap_wdata_d;
      cap_wr_q     <= cap_wr_d;
      stable_rep_q <= stable_rep_d;
      err_pulse_q  <= |err_now;
      // Clear wins over same-cycle updates, but the pulse above is still issued.
      if (clr_i) begin
        err_vec_q <= '0;
        err_cnt_q <= '0;
        txn_cnt_q <= '0;
      end else begin
        err_vec_q <= err_vec_q | err_now;
        if ((|err_now) && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + CNT_WIDTH'(1);
        if (txn_done) txn_cnt_q <= txn_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  assign chk_err_o     = err_pulse_q;
  assign chk_err_vec_o = err_vec_q;
  assign chk_err_cnt_o = err_cnt_q;
  assign chk_txn_cnt_o = txn_cnt_q;

endmodule

// File: tb/tb_mem_protocol_checker.sv
// Directed self-checking bench for mem_protocol_checker (MAX_WAIT=2, CNT_WIDTH=4).
// Expectations for the DATA bit follow the SCOREBOARD_EN macro.
module tb_mem_protocol_checker;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        wr_rd_i;
  logic [3:0]  addr_i;
  logic [15:0] wdata_i;
  logic [15:0] rdata_o;
  logic        ready_o;
  logic        clr_i;
  logic        chk_err_o;
  logic [5:0]  chk_err_vec_o;
  logic [3:0]  chk_err_cnt_o;
  logic [3:0]  chk_txn_cnt_o;

  int checks   = 0;
  int failures = 0;

`ifdef SCOREBOARD_EN
  localparam logic [5:0] DATA_VEC   = 6'b100000;
  localparam logic       DATA_PULSE = 1'b1;
  localparam logic [3:0] DATA_CNT   = 4'd1;
`else
  localparam logic [5:0] DATA_VEC   = 6'b000000;
  localparam logic       DATA_PULSE = 1'b0;
  localparam logic [3:0] DATA_CNT   = 4'd0;
`endif

  mem_protocol_checker #(
    .ADDR_WIDTH(4),
    .WIDTH(16),
    .MAX_WAIT(2),
    .CNT_WIDTH(4)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .valid_i(valid_i),
    .wr_rd_i(wr_rd_i),
    .addr_i(addr_i),
    .wdata_i(wdata_i),
    .rdata_o(rdata_o),
    .ready_o(ready_o),
    .clr_i(clr_i),
    .chk_err_o(chk_err_o),
    .chk_err_vec_o(chk_err_vec_o),
    .chk_err_cnt_o(chk_err_cnt_o),
    .chk_txn_cnt_o(chk_txn_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic wr, input logic [3:0] a,
                       input logic [15:0] wd, input logic rdy, input logic [15:0] rd);
    valid_i = v;
    wr_rd_i = wr;
    addr_i  = a;
    wdata_i = wd;
    ready_o = rdy;
    rdata_o = rd;
  endtask

  task automatic test_reset();
    clr_i = 1'b0;
    rst_i = 1'b1;
    drive(0, 0, 0, 16'h0, 0, 16'h0);
    repeat (3) tick();
    checks++; if (chk_err_vec_o !== 6'b0) begin failures++; $display("[TB] FAIL reset_vec actual=%b required=%b", chk_err_vec_o, 6'b0); end
    checks++; if (chk_err_cnt_o !== 4'd0) begin failures++; $display("[TB] FAIL reset_errcnt actual=%0d required=0", chk_err_cnt_o); end
    checks++; if (chk_txn_cnt_o !== 4'd0) begin failures++; $display("[TB] FAIL reset_txncnt actual=%0d required=0", chk_txn_cnt_o); end
    checks++; if (chk_err_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_pulse actual=%b required=0", chk_err_o); end
    rst_i = 1'b0;
    drive(0, 0, 0, 16'h0, 1, 16'h0);
    tick();
    checks++; if (chk_err_o !== 1'b1) begin failures++; $display("[TB] FAIL rst_pulse actual=%b required=1", chk_err_o); end
    checks++; if (chk_err_vec_o !== 6'b000001) begin failures++; $display("[TB] FAIL rst_vec actual=%b required=%b", chk_err_vec_o, 6'b000001); end
    checks++; if (chk_err_cnt_o !== 4'd1) begin failures++; $display("[TB] FAIL rst_errcnt actual=%0d required=1", chk_err_cnt_o); end
    drive(0, 0, 0, 16'h0, 0, 16'h0);
    tick();
    checks++; if (chk_err_o !== 1'b0) begin failures++; $display("[TB] FAIL rst_pulse_end actual=%b required=0", chk_err_o); end
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    checks++; if (chk_err_vec_o !== 6'b0) begin failures++; $display("[TB] FAIL clr_vec actual=%b required=%b", chk_err_vec_o, 6'b0); end
    checks++; if (chk_err_cnt_o !== 4'd0) begin failures++; $display("[TB] FAIL clr_errcnt actual=%0d required=0", chk_err_cnt_o); end
  endtask

  task automatic test_handshake();
    drive(1, 1, 3, 16'hA5A5, 0, 16'h0);
    tick();
    tick();
    drive(1, 1, 3, 16'hA5A5, 1, 16'h0);
    tick();
    checks++; if (chk_txn_cnt_o !== 4'd1) begin failures++; $display("[TB] FAIL hs_txn actual=%0d required=1", chk_txn_cnt_o); end
    checks++; if (chk_err_vec_o !== 6'b0) begin failures++; $display("[TB] FAIL hs_vec actual=%b required=%b", chk_err_vec_o, 6'b0); end
    checks++; if (chk_err_o !== 1'b0) begin failures++; $display("[TB] FAIL hs_pulse actual=%b required=0", chk_err_o); end
    // Ready never comes within the window: the third waiting sample times out.
    drive(1, 1, 3, 16'hA5A5, 0, 16'h0);
    repeat (3) tick();
    checks++; if (chk_err_vec_o !== 6'b000010) begin failures++; $display("[TB] FAIL to_vec actual=%b required=%b", chk_err_vec_o, 6'b000010); end
    checks++; if (chk_err_cnt_o !== 4'd1) begin failures++; $display("[TB] FAIL to_errcnt actual=%0d required=1", chk_err_cnt_o); end
    checks++; if (chk_err_o !== 1'b1) begin failures++; $display("[TB] FAIL to_pulse actual=%b required=1", chk_err_o); end
    checks++; if (chk_txn_cnt_o !== 4'd1) begin failures++; $display("[TB] FAIL to_txn actual=%0d required=1", chk_txn_cnt_o); end
    drive(1, 1, 3, 16'hA5A5, 1, 16'h0);
    tick();
    checks++; if (chk_txn_cnt_o !== 4'd2) begin failures++; $display("[TB] FAIL to_retry_txn actual=%0d required=2", chk_txn_cnt_o); end
    checks++; if (chk_err_o !== 1'b0) begin failures++; $display("[TB] FAIL to_retry_pulse actual=%b required=0", chk_err_o); end
    drive(0, 0, 0, 16'h0, 0, 16'h0);
    tick();
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    drive(1, 1, 1, 16'h1111, 1, 16'h0);
    tick();
    drive(1, 1, 2, 16'h2222, 1, 16'h0);
    tick();
    drive(1, 1, 3, 16'h3333, 1, 16'h0);
    tick();
    checks++; if (chk_txn_cnt_o !== 4'd3) begin failures++; $display("[TB] FAIL b2b_txn actual=%0d required=3", chk_txn_cnt_o); end
    checks++; if (chk_err_o !== 1'b0) begin failures++; $display("[TB] FAIL b2b_pulse actual=%b required=0", chk_err_o); end
    drive(1, 1, 6, 16'h6666, 0, 16'h0);
    tick();
    drive(1, 1, 6, 16'h6666, 1, 16'h0);
    tick();
    checks++; if (chk_txn_cnt_o !== 4'd4) begin failures++; $display("[TB] FAIL b2b_wait_txn actual=%0d required=4", chk_txn_cnt_o); end
    checks++; if (chk_err_vec_o !== 6'b0) begin failures++; $display("[TB] FAIL b2b_vec actual=%b required=%b", chk_err_vec_o, 6'b0); end
    for (int i = 0; i < 12; i++) begin
      drive(1, 1, 4'(i), 16'(i), 1, 16'h0);
      tick();
    end
    checks++; if (chk_txn_cnt_o !== 4'd0) begin failures++; $display("[TB] FAIL txn_wrap actual=%0d required=0", chk_txn_cnt_o); end
    drive(0, 0, 0, 16'h0, 0, 16'h0);
    tick();
  endtask

  task automatic test_violations();
    drive(1, 1, 3, 16'hA5A5, 0, 16'h0);
    tick();
    drive(1, 1, 4, 16'hA5A5, 0, 16'h0);
    tick();
    checks++; if (chk_err_vec_o !== 6'b001000) begin failures++; $display("[TB] FAIL stable_vec actual=%b required=%b", chk_err_vec_o, 6'b001000); end
    checks++; if (chk_err_o !== 1'b1) begin failures++; $display("[TB] FAIL stable_pulse actual=%b required=1", chk_err_o); end
    drive(1, 1, 4, 16'hA5A5, 1, 16'h0);
    tick();
    checks++; if (chk_err_o !== 1'b0) begin failures++; $display("[TB] FAIL stable_once actual=%b required=0", chk_err_o); end
    checks++; if (chk_txn_cnt_o !== 4'd1) begin failures++; $display("[TB] FAIL stable_txn actual=%0d required=1", chk_txn_cnt_o); end
    drive(1, 1, 4, 16'hA5A5, 0, 16'h0);
    tick();
    drive(0, 1, 4, 16'hA5A5, 0, 16'h0);
    tick();
    checks++; if (chk_err_vec_o !== 6'b001100) begin failures++; $display("[TB] FAIL drop_vec actual=%b required=%b", chk_err_vec_o, 6'b001100); end
    checks++; if (chk_err_cnt_o !== 4'd2) begin failures++; $display("[TB] FAIL drop_errcnt actual=%0d required=2", chk_err_cnt_o); end
    drive(0, 0, 0, 16'h0, 1, 16'h0);
    tick();
    checks++; if (chk_err_vec_o !== 6'b011100) begin failures++; $display("[TB] FAIL spur_vec actual=%b required=%b", chk_err_vec_o, 6'b011100); end
    checks++; if (chk_err_cnt_o !== 4'd3) begin failures++; $display("[TB] FAIL spur_errcnt actual=%0d required=3", chk_err_cnt_o); end
    drive(0, 0, 0, 16'h0, 0, 16'h0);
    tick();
  endtask

  task automatic test_simultaneous();
    drive(1, 1, 3, 16'hA5A5, 0, 16'h0);
    tick();
    tick();
    drive(1, 1, 4, 16'hA5A5, 0, 16'h0);
    tick();
    checks++; if (chk_err_vec_o !== 6'b011110) begin failures++; $display("[TB] FAIL sim_vec actual=%b required=%b", chk_err_vec_o, 6'b011110); end
    checks++; if (chk_err_cnt_o !== 4'd4) begin failures++; $display("[TB] FAIL sim_errcnt actual=%0d required=4", chk_err_cnt_o); end
    checks++; if (chk_err_o !== 1'b1) begin failures++; $display("[TB] FAIL sim_pulse actual=%b required=1", chk_err_o); end
    drive(0, 0, 0, 16'h0, 0, 16'h0);
    tick();
    checks++; if (chk_err_o !== 1'b0) begin failures++; $display("[TB] FAIL sim_pulse_end actual=%b required=0", chk_err_o); end
    clr_i = 1'b1;
    drive(0, 0, 0, 16'h0, 1, 16'h0);
    tick();
    clr_i = 1'b0;
    checks++; if (chk_err_vec_o !== 6'b0) begin failures++; $display("[TB] FAIL clrerr_vec actual=%b required=%b", chk_err_vec_o, 6'b0); end
    checks++; if (chk_err_cnt_o !== 4'd0) begin failures++; $display("[TB] FAIL clrerr_errcnt actual=%0d required=0", chk_err_cnt_o); end
    checks++; if (chk_txn_cnt_o !== 4'd0) begin failures++; $display("[TB] FAIL clrerr_txn actual=%0d required=0", chk_txn_cnt_o); end
    checks++; if (chk_err_o !== 1'b1) begin failures++; $display("[TB] FAIL clrerr_pulse actual=%b required=1", chk_err_o); end
    drive(0, 0, 0, 16'h0, 0, 16'h0);
    tick();
  endtask

  task automatic test_saturation();
    drive(0, 0, 0, 16'h0, 1, 16'h0);
    repeat (14) tick();
    checks++; if (chk_err_cnt_o !== 4'd14) begin failures++; $display("[TB] FAIL sat_14 actual=%0d required=14", chk_err_cnt_o); end
    repeat (6) tick();
    checks++; if (chk_err_cnt_o !== 4'hF) begin failures++; $display("[TB] FAIL sat_20 actual=%0d required=15", chk_err_cnt_o); end
    checks++; if (chk_err_vec_o !== 6'b010000) begin failures++; $display("[TB] FAIL sat_vec actual=%b required=%b", chk_err_vec_o, 6'b010000); end
    drive(0, 0, 0, 16'h0, 0, 16'h0);
    tick();
    checks++; if (chk_err_cnt_o !== 4'hF) begin failures++; $display("[TB] FAIL sat_hold actual=%0d required=15", chk_err_cnt_o); end
  endtask

  task automatic test_reset_mid();
    drive(1, 0, 2, 16'h0, 0, 16'h0);
    tick();
    rst_i = 1'b1;
    drive(0, 0, 0, 16'h0, 0, 16'h0);
    tick();
    checks++; if (chk_err_cnt_o !== 4'd0) begin failures++; $display("[TB] FAIL rstmid_errcnt actual=%0d required=0", chk_err_cnt_o); end
    checks++; if (chk_err_vec_o !== 6'b0) begin failures++; $display("[TB] FAIL rstmid_vec actual=%b required=%b", chk_err_vec_o, 6'b0); end
    rst_i = 1'b0;
    tick();
    tick();
    checks++; if (chk_err_vec_o !== 6'b0) begin failures++; $display("[TB] FAIL rstmid_after_vec actual=%b required=%b", chk_err_vec_o, 6'b0); end
    checks++; if (chk_err_cnt_o !== 4'd0) begin failures++; $display("[TB] FAIL rstmid_after_cnt actual=%0d required=0", chk_err_cnt_o); end
  endtask

  task automatic test_scoreboard();
    drive(1, 1, 5, 16'h1234, 1, 16'h0);
    tick();
    drive(1, 0, 5, 16'h0, 1, 16'h1235);
    tick();
    checks++; if (chk_err_vec_o !== DATA_VEC) begin failures++; $display("[TB] FAIL sb_vec actual=%b required=%b", chk_err_vec_o, DATA_VEC); end
    checks++; if (chk_err_o !== DATA_PULSE) begin failures++; $display("[TB] FAIL sb_pulse actual=%b required=%b", chk_err_o, DATA_PULSE); end
    checks++; if (chk_err_cnt_o !== DATA_CNT) begin failures++; $display("[TB] FAIL sb_errcnt actual=%0d required=%0d", chk_err_cnt_o, DATA_CNT); end
    drive(0, 0, 0, 16'h0, 0, 16'h0);
    tick();
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    drive(1, 0, 5, 16'h0, 1, 16'h1234);
    tick();
    drive(1, 0, 7, 16'h0, 1, 16'hBEEF);
    tick();
    checks++; if (chk_err_vec_o !== 6'b0) begin failures++; $display("[TB] FAIL sb_ok_vec actual=%b required=%b", chk_err_vec_o, 6'b0); end
    checks++; if (chk_err_o !== 1'b0) begin failures++; $display("[TB] FAIL sb_unwritten_pulse actual=%b required=0", chk_err_o); end
    checks++; if (chk_txn_cnt_o !== 4'd2) begin failures++; $display("[TB] FAIL sb_txn actual=%0d required=2", chk_txn_cnt_o); end
    drive(0, 0, 0, 16'h0, 0, 16'h0);
    tick();
  endtask

  initial begin
    test_reset();
    test_handshake();
    test_back_to_back();
    test_violations();
    test_simultaneous();
    test_saturation();
    test_reset_mid();
    test_scoreboard();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
